// File: rtl/lsu_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lsu_ctrl: single-outstanding load/store sequencer over a req/gnt/rvalid  |
// | data bus, with lane alignment, load extension and optional timeout.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_ext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rf_waddr_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_GNT    = 2'd1,
    S_WAIT_RVALID = 2'd2
  } state_e;

  localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    waddr_q, waddr_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [1:0]    req_off;
  logic          misaligned;
  logic [3:0]    req_be;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ld_data;
  logic          timeout_hit;

  always_comb begin
    req_off    = addr_i[1:0];
    misaligned = (size_i == 2'b11)
               | ((size_i == 2'b01) & req_off[0])
               | ((size_i == 2'b10) & (req_off != 2'b00));
    case (size_i)
      2'b00:   req_be = 4'b0001 << req_off;
      2'b01:   req_be = 4'b0011 << req_off;
      default: req_be = 4'b1111;
    endcase
  end

  // Load lane extraction uses the offset captured at accept, not the live address.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = data_rdata_i[7:0];
      2'd1:    rd_byte = data_rdata_i[15:8];
      2'd2:    rd_byte = data_rdata_i[23:16];
      default: rd_byte = data_rdata_i[31:24];
    endcase
    rd_half = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (size_q)
      2'b00:   ld_data = sext_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      2'b01:   ld_data = sext_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      default: ld_data = data_rdata_i;
    endcase
  end

  assign timeout_hit = (TIMEOUT > 0) && (timer_q == TW'(TLIM));

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sext_d     = sext_q;
    off_d      = off_q;
    waddr_d    = waddr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WAIT_GNT;
            timer_d = '0;
            addr_d  = {addr_i[31:2], 2'b00};
            we_d    = we_i;
            be_d    = req_be;
            wdata_d = wdata_i << {req_off, 3'b000};
            size_d  = size_i;
            sext_d  = sign_ext_i;
            off_d   = req_off;
            waddr_d = rf_waddr_i;
          end
        end
      end
      S_WAIT_GNT: begin
        // Timeout takes precedence: a grant in the expiring cycle is abandoned.
        if (timeout_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
          if (data_gnt_i) state_d = S_WAIT_RVALID;
        end
      end
      S_WAIT_RVALID: begin
        if (data_rvalid_i) begin
          state_d = S_IDLE;
          if (data_err_i) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!we_q) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = waddr_q;
              rf_wdata_d = ld_data;
            end
          end
        end else if (timeout_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      off_q      <= '0;
      waddr_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
      waddr_q    <= waddr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign data_req_o   = (state_q == S_WAIT_GNT);
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire
